pipe_hazard_ctrl: RTL
=====================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 255 (range 1..255); maximum consecutive MEM-wait cycles before a bus error.
REQ-002 clk  input  1  pipeline clock; all state is updated on the rising edge.
REQ-003 rst_i  input  1  reset, asynchronous and active-high.
REQ-004 id_valid_i  input  1  the instruction in ID is valid.
REQ-005 id_rs1_addr_i / id_rs2_addr_i  input  5 each  source register addresses of the instruction in ID.
REQ-006 id_rs1_used_i / id_rs2_used_i  input  1 each  the corresponding source operand is actually read.
REQ-007 id_instr_jal_i  input  1  the instruction in ID is a JAL.
REQ-008 ex_valid_i, ex_dmem_rd_en_i  input  1 each  EX holds a valid instruction / EX holds a load.
REQ-009 ex_reg_wr_addr_i  input  5  destination register address of the instruction in EX.
REQ-010 ex_redirect_i  input  1  EX resolved a taken branch or a JALR.
REQ-011 mem_req_i, dmem_ack_i  input  1 each  MEM stage has an outstanding data access / the data memory completes it this cycle.
REQ-012 if_stall_o, id_stall_o, ex_stall_o, mem_stall_o  output  1 each  hold the named stage's pipeline register.
REQ-013 if_squash_o, id_squash_o  output  1 each  invalidate the IF-ID register / the ID-EX register on the next write.
REQ-014 bus_err_o  output  1  sticky data-memory timeout flag.
REQ-015 stall_cycles_o  output  32  count of mem-stall cycles.
REQ-016 flush_count_o  output  32  count of redirect flushes.

Function
REQ-017 FSM states: RUN and MEM_WAIT; the stall and squash outputs are combinational from the state and the inputs.
REQ-018 mem_req_i=1 with dmem_ack_i=0 (in either state) SHALL assert all four *_stall_o, force both *_squash_o=0, and move the FSM to MEM_WAIT.
REQ-019 In MEM_WAIT, dmem_ack_i=1 SHALL deassert the stalls in that same cycle and return the FSM to RUN on the next edge.
REQ-020 An 8-bit wait counter SHALL clear on entering MEM_WAIT and increment on each MEM_WAIT cycle; reaching TIMEOUT_CYCLES SHALL set bus_err_o, release all stalls, and return the FSM to RUN.
REQ-021 Redirect: when not mem-stalled, ex_redirect_i=1 SHALL assert if_squash_o=1 and id_squash_o=1 for exactly that cycle, with no stalls.
REQ-022 Load-use: when not mem-stalled and ex_redirect_i=0, a hazard exists if all of the following hold:
- ex_valid_i=1, ex_dmem_rd_en_i=1 and ex_reg_wr_addr_i!=0;
- id_valid_i=1;
- (rs1_used and rs1 == wr addr) or (rs2_used and rs2 == wr addr).
In that case if_stall_o=1, id_squash_o=1, id_stall_o=0 and if_squash_o=0 (one bubble is inserted).
REQ-023 JAL: when not mem-stalled, ex_redirect_i=0 and there is no load-use hazard, id_instr_jal_i=1 SHALL assert if_squash_o=1.
REQ-024 Priority: mem-stall > ex_redirect_i > load-use > JAL. A redirect that arrives during a mem-stall SHALL be acted on in the first unstalled cycle, because EX is held.
REQ-025 A load-use hazard SHALL cause exactly one bubble; no state is kept for it.
REQ-026 In RUN with no events, all stall and squash outputs SHALL be 0.

Reset
REQ-027 rst_i asserted SHALL immediately force:
- state = RUN;
- wait counter = 0;
- bus_err_o = 0;
- both counters = 0;
- all *_stall_o = 0;
- if_squash_o = 1 and id_squash_o = 1.
REQ-028 rst_i asserted during MEM_WAIT SHALL abandon the wait with no bus_err_o.
REQ-029 bus_err_o SHALL be cleared only by reset.

Configuration
REQ-030 With macro PIPE_HAZARD_PERF_CNT_EN defined:
- stall_cycles_o SHALL increment on every cycle with mem_stall_o=1;
- flush_count_o SHALL increment on every redirect flush per REQ-021;
- both counters saturate at 32'hFFFF_FFFF.
REQ-031 Without the macro, both counters SHALL be constant 0 and no counter flops SHALL be synthesised.

Verification
REQ-032 Load-use: EX load to x5, ID uses rs1=5 with rs1_used=1 -> if_stall_o=1 and id_squash_o=1 for 1 cycle; with wr addr x0 instead -> no stall.
REQ-033 Memory wait: mem_req_i=1, dmem_ack_i low for 3 cycles then high -> all stalls high for exactly 3 cycles, and stall_cycles_o=3 when the macro is enabled.
REQ-034 Timeout: TIMEOUT_CYCLES=4, no ack -> bus_err_o rises after 4 MEM_WAIT cycles, stalls drop, bus_err_o stays high until rst_i.
REQ-035 Simultaneous events: ex_redirect_i and a load-use hazard in the same cycle -> both squashes asserted and if_stall_o=0; redirect during a mem-stall -> squashes appear in the ack cycle; flush_count_o increments by 1 per redirect.
REQ-036 Asynchronous reset: rst_i pulsed mid-MEM_WAIT between clock edges -> state and outputs per REQ-027 take effect without a clock edge.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl_if
// Groups the pipeline-facing signals of the hazard controller.
//   master : pipeline side. Drives the ID/EX/MEM status and reads back the
//            stall/squash controls, the bus error flag and the counters.
//   slave  : the hazard controller itself.
// Signals:
//   id_valid_i, id_rs1_addr_i, id_rs2_addr_i, id_rs1_used_i, id_rs2_used_i,
//   id_instr_jal_i                   instruction currently in ID
//   ex_valid_i, ex_dmem_rd_en_i,
//   ex_reg_wr_addr_i, ex_redirect_i  instruction currently in EX
//   mem_req_i, dmem_ack_i            data access outstanding in MEM / completion
//   if_stall_o .. mem_stall_o        hold the named pipeline register
//   if_squash_o, id_squash_o         invalidate IF-ID / ID-EX on next write
//   bus_err_o                        sticky data-memory timeout flag
//   stall_cycles_o, flush_count_o    performance counters (0 when disabled)
// -----------------------------------------------------------------------------
interface pipe_hazard_ctrl_if;
  logic        id_valid_i;
  logic [4:0]  id_rs1_addr_i;
  logic [4:0]  id_rs2_addr_i;
  logic        id_rs1_used_i;
  logic        id_rs2_used_i;
  logic        id_instr_jal_i;
  logic        ex_valid_i;
  logic        ex_dmem_rd_en_i;
  logic [4:0]  ex_reg_wr_addr_i;
  logic        ex_redirect_i;
  logic        mem_req_i;
  logic        dmem_ack_i;
  logic        if_stall_o;
  logic        id_stall_o;
  logic        ex_stall_o;
  logic        mem_stall_o;
  logic        if_squash_o;
  logic        id_squash_o;
  logic        bus_err_o;
  logic [31:0] stall_cycles_o;
  logic [31:0] flush_count_o;

  modport master (
    output id_valid_i, id_rs1_addr_i, id_rs2_addr_i, id_rs1_used_i,
           id_rs2_used_i, id_instr_jal_i, ex_valid_i, ex_dmem_rd_en_i,
           ex_reg_wr_addr_i, ex_redirect_i, mem_req_i, dmem_ack_i,
    input  if_stall_o, id_stall_o, ex_stall_o, mem_stall_o, if_squash_o,
           id_squash_o, bus_err_o, stall_cycles_o, flush_count_o
  );

  modport slave (
    input  id_valid_i, id_rs1_addr_i, id_rs2_addr_i, id_rs1_used_i,
           id_rs2_used_i, id_instr_jal_i, ex_valid_i, ex_dmem_rd_en_i,
           ex_reg_wr_addr_i, ex_redirect_i, mem_req_i, dmem_ack_i,
    output if_stall_o, id_stall_o, ex_stall_o, mem_stall_o, if_squash_o,
           id_squash_o, bus_err_o, stall_cycles_o, flush_count_o
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Hazard controller for a classic IF/ID/EX/MEM pipeline. Resolves, in priority
// order: data-memory wait stalls, EX redirects (taken branch / JALR), load-use
// hazards (one bubble) and JAL fetch squashes. A data access that stays
// unacknowledged for TIMEOUT_CYCLES cycles in MEM_WAIT sets a sticky bus error
// and releases the pipeline; the pipeline is expected to drop mem_req_i once it
// sees bus_err_o.
// Parameters:
//   TIMEOUT_CYCLES  1..255, MEM_WAIT cycles before the bus error fires.
// Ports:
//   clk    pipeline clock, rising edge
//   rst_i  asynchronous active-high reset
//   bus    pipe_hazard_ctrl_if.slave (pipeline status in, stall/squash out)
// Build option:
//   PIPE_HAZARD_PERF_CNT_EN  when defined, stall_cycles_o counts mem-stall
//   cycles and flush_count_o counts redirect flushes (both saturating);
//   otherwise both read as constant 0 and no counter flops exist.
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic               clk,
  input logic               rst_i,
  pipe_hazard_ctrl_if.slave bus
);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  // Value of the wait counter during the last MEM_WAIT cycle before timeout.
  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT_CYCLES - 1);

  state_t     state, state_nxt;
  logic [7:0] wait_cnt, wait_cnt_nxt;
  logic       bus_err, bus_err_nxt;
  logic       mem_stall;
  logic       load_use;

  logic if_stall, id_stall, ex_stall, mem_stall_q;
  logic if_squash, id_squash;

  // An outstanding access with no completion this cycle freezes everything.
  assign mem_stall = bus.mem_req_i && !bus.dmem_ack_i;

  // A load in EX whose result is read by the instruction in ID. x0 is never a
  // real dependency.
  assign load_use = bus.ex_valid_i && bus.ex_dmem_rd_en_i &&
                    (bus.ex_reg_wr_addr_i != 5'd0) && bus.id_valid_i &&
                    ((bus.id_rs1_used_i && (bus.id_rs1_addr_i == bus.ex_reg_wr_addr_i)) ||
                     (bus.id_rs2_used_i && (bus.id_rs2_addr_i == bus.ex_reg_wr_addr_i)));

  // NOTE: every variable driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    bus_err_nxt  = bus_err;
    case (state)
      RUN: begin
        if (mem_stall) begin
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = 8'd0;
        end
      end
      MEM_WAIT: begin
        wait_cnt_nxt = wait_cnt + 8'd1;
        if (!mem_stall) begin
          // Completed (or request withdrawn): stalls already dropped this cycle.
          state_nxt = RUN;
        end else if (wait_cnt == LAST_WAIT) begin
          // TIMEOUT_CYCLES MEM_WAIT cycles spent: give up on the access.
          state_nxt   = RUN;
          bus_err_nxt = 1'b1;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of process ordering.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state    <= RUN;
      wait_cnt <= 8'd0;
      bus_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      bus_err  <= bus_err_nxt;
    end
  end

  // Stall/squash decode. Reset is included combinationally so the pipeline
  // registers see squash immediately, without waiting for a clock edge.
  always_comb begin
    if_stall    = 1'b0;
    id_stall    = 1'b0;
    ex_stall    = 1'b0;
    mem_stall_q = 1'b0;
    if_squash   = 1'b0;
    id_squash   = 1'b0;
    if (rst_i) begin
      if_squash = 1'b1;
      id_squash = 1'b1;
    end else if (mem_stall) begin
      if_stall    = 1'b1;
      id_stall    = 1'b1;
      ex_stall    = 1'b1;
      mem_stall_q = 1'b1;
    end else if (bus.ex_redirect_i) begin
      // EX is held during a mem-stall, so a pending redirect lands here in the
      // first free cycle.
      if_squash = 1'b1;
      id_squash = 1'b1;
    end else if (load_use) begin
      // Keep the consumer in ID and send a bubble into EX.
      if_stall  = 1'b1;
      id_squash = 1'b1;
    end else if (bus.id_instr_jal_i) begin
      // Target known in ID: drop the sequentially fetched instruction.
      if_squash = 1'b1;
    end
  end

  assign bus.if_stall_o  = if_stall;
  assign bus.id_stall_o  = id_stall;
  assign bus.ex_stall_o  = ex_stall;
  assign bus.mem_stall_o = mem_stall_q;
  assign bus.if_squash_o = if_squash;
  assign bus.id_squash_o = id_squash;
  assign bus.bus_err_o   = bus_err;

`ifdef PIPE_HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles;
  logic [31:0] flush_count;
  logic        redirect_flush;

  assign redirect_flush = !mem_stall && bus.ex_redirect_i;

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      stall_cycles <= 32'd0;
      flush_count  <= 32'd0;
    end else begin
      if (mem_stall && (stall_cycles != 32'hFFFF_FFFF))
        stall_cycles <= stall_cycles + 32'd1;
      if (redirect_flush && (flush_count != 32'hFFFF_FFFF))
        flush_count <= flush_count + 32'd1;
    end
  end

  assign bus.stall_cycles_o = stall_cycles;
  assign bus.flush_count_o  = flush_count;
`else
  assign bus.stall_cycles_o = 32'd0;
  assign bus.flush_count_o  = 32'd0;
`endif

endmodule
